// File: rtl/fpu_prim_pkg.sv
// Shared constants for FPU datapath storage primitives.
package fpu_prim_pkg;

  localparam int unsigned DEFAULT_WIDTH = 55;
  localparam int unsigned MAX_WIDTH     = 128;

  // Sliced down to the bank width by each user.
  localparam logic [MAX_WIDTH-1:0] RST_VAL = '0;

endpackage

// File: rtl/clken_dff_bank_if.sv
// Data/scan/gated-clock bundle for clken_dff_bank.
interface clken_dff_bank_if #(
  parameter int unsigned WIDTH = fpu_prim_pkg::DEFAULT_WIDTH
);

  logic             enb_l;
  logic             se;
  logic             si;
  logic [WIDTH-1:0] din;
  logic             gclk;
  logic [WIDTH-1:0] q;
  logic             so;

  modport master (
    output enb_l, se, si, din,
    input  gclk, q, so
  );

  modport slave (
    input  enb_l, se, si, din,
    output gclk, q, so
  );

endinterface

// File: rtl/clken_gate.sv
// Glitch-free clock gate: low-transparent enable latch ANDed with the clock.
module clken_gate (
  input  logic clk_i,
  input  logic en_i,
  output logic gclk_o
);

  logic en_q;

  // Enable may only change while clk_i is low, so a high phase is never cut short.
  always_latch begin
    if (!clk_i) en_q <= en_i;
  end

  assign gclk_o = clk_i & en_q;

endmodule

// File: rtl/clken_dff_bank.sv
// Clock-gated scan register bank. Define SCAN_CLK_FORCE_EN to let se open the gate.
module clken_dff_bank
  import fpu_prim_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             rclk,
  input  logic             rst,
  clken_dff_bank_if.slave  bus
);

  logic             gate_en;
  logic             gclk;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] bank_d;
  logic [WIDTH-1:0] shift_val;

  // Reset opens the gate so it clears the bank even with enb_l high.
`ifdef SCAN_CLK_FORCE_EN
  assign gate_en = ~bus.enb_l | rst | bus.se;
`else
  assign gate_en = ~bus.enb_l | rst;
`endif

  clken_gate u_gate (
    .clk_i  (rclk),
    .en_i   (gate_en),
    .gclk_o (gclk)
  );

  if (WIDTH == 1) begin : g_shift_w1
    assign shift_val = bus.si;
  end else begin : g_shift_wn
    assign shift_val = {bus.si, bank_q[WIDTH-1:1]};
  end

  always_comb begin
    bank_d = bus.din;
    if (bus.se) bank_d = shift_val;
  end

  always_ff @(posedge gclk) begin
    if (rst) bank_q <= RST_VAL[WIDTH-1:0];
    else     bank_q <= bank_d;
  end

  assign bus.gclk = gclk;
  assign bus.q    = bank_q;
  assign bus.so   = bank_q[0];

endmodule

// File: tb/tb_clken_dff_bank.sv
// Directed bench for clken_dff_bank: 55-bit and 8-bit instances.
module tb_clken_dff_bank;

  logic rclk;
  logic rst55;
  logic rst8;
  int   n_vec;
  int   n_err;

  clken_dff_bank_if #(.WIDTH(55)) bus55 ();
  clken_dff_bank_if #(.WIDTH(8))  bus8  ();

  clken_dff_bank #(.WIDTH(55)) u_dut55 (
    .rclk (rclk),
    .rst  (rst55),
    .bus  (bus55)
  );

  clken_dff_bank #(.WIDTH(8)) u_dut8 (
    .rclk (rclk),
    .rst  (rst8),
    .bus  (bus8)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    bus55.enb_l = 1'b0; bus55.se = 1'b0; bus55.si = 1'b0;
    bus55.din   = {55{1'b1}};
    bus8.enb_l  = 1'b0; bus8.se  = 1'b0; bus8.si  = 1'b0;
    bus8.din    = 8'hFF;
    rst55 = 1'b0; rst8 = 1'b0;
    step();
    n_vec++;
    if (bus55.q !== 55'h7F_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL preload55 got %h want %h", bus55.q, 55'h7F_FFFF_FFFF_FFFF);
    end
    bus55.enb_l = 1'b1; bus8.enb_l = 1'b1;
    rst55 = 1'b1; rst8 = 1'b1;
    step();
    n_vec++;
    if (bus55.q !== 55'h0) begin
      n_err++; $display("FAIL reset_q55 got %h want 0", bus55.q);
    end
    n_vec++;
    if (bus55.so !== 1'b0) begin
      n_err++; $display("FAIL reset_so55 got %b want 0", bus55.so);
    end
    n_vec++;
    if (bus8.q !== 8'h00) begin
      n_err++; $display("FAIL reset_q8 got %h want 00", bus8.q);
    end
    rst55 = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_load();
    bus55.enb_l = 1'b0; bus55.se = 1'b0;
    bus55.din   = 55'h2A_5555_5555_5555;
    step();
    n_vec++;
    if (bus55.q !== 55'h2A_5555_5555_5555) begin
      n_err++; $display("FAIL load_q got %h want %h", bus55.q, 55'h2A_5555_5555_5555);
    end
    n_vec++;
    if (bus55.so !== 1'b1) begin
      n_err++; $display("FAIL load_so got %b want 1", bus55.so);
    end
    @(negedge rclk); #1;
    n_vec++;
    if (bus55.gclk !== 1'b0) begin
      n_err++; $display("FAIL gclk_low_phase got %b want 0", bus55.gclk);
    end
    @(posedge rclk); #1;
  endtask

  task automatic test_gating_hold();
    bus55.enb_l = 1'b0; bus55.din = 55'h123;
    step();
    n_vec++;
    if (bus55.q !== 55'h123) begin
      n_err++; $display("FAIL hold_preload got %h want 123", bus55.q);
    end
    bus55.enb_l = 1'b1; bus55.din = 55'h456;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (bus55.gclk !== 1'b0 || bus55.q !== 55'h123) begin
        n_err++;
        $display("FAIL hold_cycle%0d got gclk=%b q=%h want gclk=0 q=123", i, bus55.gclk, bus55.q);
      end
    end
  endtask

  task automatic test_enable_race();
    #2;
    bus55.enb_l = 1'b0; bus55.din = 55'h789;
    #1;
    n_vec++;
    if (bus55.gclk !== 1'b0 || bus55.q !== 55'h123) begin
      n_err++;
      $display("FAIL race_same_cycle got gclk=%b q=%h want gclk=0 q=123", bus55.gclk, bus55.q);
    end
    step();
    n_vec++;
    if (bus55.gclk !== 1'b1 || bus55.q !== 55'h789) begin
      n_err++;
      $display("FAIL race_next_edge got gclk=%b q=%h want gclk=1 q=789", bus55.gclk, bus55.q);
    end
    #3;
    n_vec++;
    if (bus55.gclk !== 1'b1) begin
      n_err++; $display("FAIL race_full_width got %b want 1", bus55.gclk);
    end
    @(negedge rclk); #1;
    n_vec++;
    if (bus55.gclk !== 1'b0) begin
      n_err++; $display("FAIL race_low_phase got %b want 0", bus55.gclk);
    end
    bus55.enb_l = 1'b1; bus55.din = 55'hABC;
    step();
    n_vec++;
    if (bus55.q !== 55'h789) begin
      n_err++; $display("FAIL race_reclose got %h want 789", bus55.q);
    end
  endtask

  task automatic test_reset_vs_scan();
    bus55.enb_l = 1'b1; bus55.se = 1'b1; bus55.si = 1'b1;
    rst55 = 1'b1;
    step();
    n_vec++;
    if (bus55.q !== 55'h0) begin
      n_err++; $display("FAIL rst_beats_se got %h want 0", bus55.q);
    end
    rst55 = 1'b0; bus55.se = 1'b0; bus55.si = 1'b0;
  endtask

  task automatic test_scan_shift();
    bus8.enb_l = 1'b0; bus8.se = 1'b0; bus8.din = 8'hA5;
    step();
    n_vec++;
    if (bus8.q !== 8'hA5) begin
      n_err++; $display("FAIL scan_preload got %h want a5", bus8.q);
    end
    bus8.se = 1'b1; bus8.si = 1'b1; bus8.din = 8'h00;
    step();
    n_vec++;
    if (bus8.q !== 8'hD2 || bus8.so !== 1'b0) begin
      n_err++; $display("FAIL scan_first got q=%h so=%b want q=d2 so=0", bus8.q, bus8.so);
    end
    for (int i = 0; i < 7; i++) step();
    n_vec++;
    if (bus8.q !== 8'hFF || bus8.so !== 1'b1) begin
      n_err++; $display("FAIL scan_full got q=%h so=%b want q=ff so=1", bus8.q, bus8.so);
    end
  endtask

  task automatic test_scan_clk_force();
    bus8.enb_l = 1'b1; bus8.se = 1'b1; bus8.si = 1'b0;
    step();
`ifdef SCAN_CLK_FORCE_EN
    n_vec++;
    if (bus8.gclk !== 1'b1 || bus8.q !== 8'h7F) begin
      n_err++; $display("FAIL force_edge1 got gclk=%b q=%h want gclk=1 q=7f", bus8.gclk, bus8.q);
    end
    step();
    n_vec++;
    if (bus8.q !== 8'h3F) begin
      n_err++; $display("FAIL force_edge2 got %h want 3f", bus8.q);
    end
`else
    n_vec++;
    if (bus8.gclk !== 1'b0 || bus8.q !== 8'hFF) begin
      n_err++; $display("FAIL noforce_edge1 got gclk=%b q=%h want gclk=0 q=ff", bus8.gclk, bus8.q);
    end
    step();
    n_vec++;
    if (bus8.gclk !== 1'b0 || bus8.q !== 8'hFF) begin
      n_err++; $display("FAIL noforce_edge2 got gclk=%b q=%h want gclk=0 q=ff", bus8.gclk, bus8.q);
    end
`endif
    bus8.se = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load();
    test_gating_hold();
    test_enable_race();
    test_reset_vs_scan();
    test_scan_shift();
    test_scan_clk_force();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
